// File: rtl/mmio_pkg.sv
// mmio_pkg: register map, FSM states and default window base for the MMIO PWM block
package mmio_pkg;
    localparam logic [31:0] BASE_ADDR_DEF = 32'hFFFF_FF00;
    localparam logic [7:0] OFF_CTRL      = 8'h00;
    localparam logic [7:0] OFF_PRESCALE  = 8'h04;
    localparam logic [7:0] OFF_TGT       = 8'h08;
    localparam logic [7:0] OFF_FADE_RATE = 8'h18;
    localparam logic [7:0] OFF_CUR       = 8'h20;
    typedef enum logic [1:0] {DISABLED, RUN, FADE} pwm_state_t;
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one channel's target/current/active duty, fade step and registered compare
module pwm_channel (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tgt_we,
    input  logic [7:0] wdata,
    input  logic       copy,
    input  logic       step,
    input  logic       boundary,
    input  logic       en,
    input  logic [7:0] pwm_cnt,
    output logic [7:0] tgt,
    output logic [7:0] cur,
    output logic       pwm
);
    logic [7:0] act, cur_nx;
    // stepping toward the target can never leave 0..255, so no explicit clamp is needed
    always_comb cur_nx = copy ? tgt : !step ? cur : (cur < tgt) ? cur + 8'd1 : (cur > tgt) ? cur - 8'd1 : cur;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tgt <= '0;
            cur <= '0;
            act <= '0;
            pwm <= 1'b0;
        end else begin
            if (tgt_we) tgt <= wdata;
            cur <= cur_nx;
            if (boundary) act <= cur;
            pwm <= en && (pwm_cnt < act);
        end
    end
endmodule

// File: rtl/mmio_pwm.sv
// mmio_pwm: memory-mapped 4-channel PWM with prescaler, period counter and fade FSM
module mmio_pwm import mmio_pkg::*; #(
    parameter logic [31:0] BASE_ADDR    = BASE_ADDR_DEF,
    parameter logic [15:0] PRESCALE_RST = 16'd46
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        write_mem,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data_clocked,
    output logic        red,
    output logic        green,
    output logic        blue,
    output logic        led
);
    pwm_state_t state, state_nx;
    logic [7:0] off, fade_rate, pwm_cnt, fade_cnt;
    logic [1:0] ctrl;
    logic [15:0] prescale, pre_cnt;
    logic hit, wr, en, tick, boundary, step, unused_wdata;
    logic [7:0] tgt [4];
    logic [7:0] cur [4];
    logic [3:0] pwm;
    logic [31:0] rdata;
    assign off = address[7:0];
    assign hit = address[31:8] == BASE_ADDR[31:8];
    assign wr = write_mem && hit && address[1:0] == 2'b00 && funct3 <= 3'b010;
    assign unused_wdata = ^write_data[31:16];
    assign en = state != DISABLED;
    assign tick = en && pre_cnt == prescale;
    assign boundary = tick && pwm_cnt == 8'hFF;
    assign step = state == FADE && boundary && fade_cnt == fade_rate;
    always_comb state_nx = !ctrl[0] ? DISABLED : ctrl[1] ? FADE : RUN;
    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                OFF_CTRL:      rdata = {30'd0, ctrl};
                OFF_PRESCALE:  rdata = {16'd0, prescale};
                OFF_FADE_RATE: rdata = {24'd0, fade_rate};
                default:
                    for (int i = 0; i < 4; i++) begin
                        if (off == OFF_TGT + 8'(4 * i)) rdata = {24'd0, tgt[i]};
                        if (off == OFF_CUR + 8'(4 * i)) rdata = {24'd0, cur[i]};
                    end
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= DISABLED;
            ctrl <= '0;
            prescale <= PRESCALE_RST;
            fade_rate <= '0;
            pre_cnt <= '0;
            pwm_cnt <= '0;
            fade_cnt <= '0;
            read_data_clocked <= '0;
        end else begin
            state <= state_nx;
            if (wr && off == OFF_CTRL) ctrl <= write_data[1:0];
            if (wr && off == OFF_PRESCALE) prescale <= write_data[15:0];
            if (wr && off == OFF_FADE_RATE) fade_rate <= write_data[7:0];
            pre_cnt <= (!en || tick || (wr && off == OFF_PRESCALE)) ? '0 : pre_cnt + 16'd1;
            pwm_cnt <= !en ? '0 : pwm_cnt + {7'd0, tick};
            fade_cnt <= state != FADE ? '0 : !boundary ? fade_cnt : fade_cnt == fade_rate ? '0 : fade_cnt + 8'd1;
            read_data_clocked <= rdata;
        end
    end
    // channel order 0..3 = LED, R, G, B, matching the TGT/CUR register order
    genvar i;
    for (i = 0; i < 4; i++) begin : g_ch
        pwm_channel u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .tgt_we   (wr && off == OFF_TGT + 8'(4 * i)),
            .wdata    (write_data[7:0]),
            .copy     (state == RUN),
            .step     (step),
            .boundary (boundary),
            .en       (en),
            .pwm_cnt  (pwm_cnt),
            .tgt      (tgt[i]),
            .cur      (cur[i]),
            .pwm      (pwm[i])
        );
    end
    assign {blue, green, red, led} = pwm;
endmodule

// File: tb/tb_mmio_pwm.sv
// tb_mmio_pwm: scoreboard bench for mmio_pwm register access, PWM duty, fade and reset
module tb_mmio_pwm;
    localparam logic [31:0] B = 32'hFFFF_FF00;
    logic clk = 1'b0, reset_n = 1'b0, write_mem = 1'b0;
    logic [2:0] funct3 = 3'b010;
    logic [31:0] address = '0, write_data = '0, read_data_clocked;
    logic red, green, blue, led;
    logic [31:0] exp_q [$];
    int checks = 0, errors = 0;
    mmio_pwm dut (
        .clk(clk), .reset_n(reset_n), .write_mem(write_mem), .funct3(funct3),
        .address(address), .write_data(write_data), .read_data_clocked(read_data_clocked),
        .red(red), .green(green), .blue(blue), .led(led)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        address = a;
        write_data = d;
        funct3 = f;
        write_mem = 1'b1;
        @(negedge clk);
        write_mem = 1'b0;
    endtask
    task automatic rd(input logic [31:0] a, input logic [31:0] e);
        address = a;
        write_mem = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        chk($sformatf("rd_%h", a), read_data_clocked, exp_q.pop_front());
    endtask
    task automatic cnt(input int sel, input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            c += int'(sel == 1 ? red : sel == 2 ? green : sel == 3 ? blue : led);
        end
    endtask
    task automatic wait_red_rise();
        int t = 0;
        while (red !== 1'b0 && t < 2000) begin @(negedge clk); t++; end
        while (red !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
        chk("red_rise_timeout", 32'(t < 2000), 32'd1);
    endtask
    initial begin
        int c, prev, last_t, nchg;
        logic [31:0] v;
        #23;
        chk("rst_outputs", {28'd0, red, green, blue, led}, 32'd0);
        chk("rst_rdata", read_data_clocked, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(B + 32'h04, 32'd46);
        chk("idle_outputs", {28'd0, red, green, blue, led}, 32'd0);
        rd(B + 32'h00, 32'd0);
        wr(B + 32'h04, 32'd0, 3'b010);
        wr(B + 32'h0C, 32'd64, 3'b000);
        rd(B + 32'h0C, 32'd64);
        wr(B + 32'h00, 32'd1, 3'b010);
        cnt(1, 200, c);
        chk("red_first_period", 32'(c), 32'd0);
        repeat (400) @(negedge clk);
        cnt(1, 256, c);
        chk("red_duty64", 32'(c), 32'd64);
        cnt(1, 256, c);
        chk("red_duty64_again", 32'(c), 32'd64);
        wr(B + 32'h10, 32'd0, 3'b010);
        cnt(2, 256, c);
        chk("green_duty0", 32'(c), 32'd0);
        wr(B + 32'h10, 32'd255, 3'b001);
        repeat (300) @(negedge clk);
        cnt(2, 256, c);
        chk("green_duty255", 32'(c), 32'd255);
        wait_red_rise();
        wr(B + 32'h10, 32'd0, 3'b010);
        cnt(2, 200, c);
        chk("green_midperiod_hold", 32'(c), 32'd200);
        repeat (100) @(negedge clk);
        cnt(2, 256, c);
        chk("green_after_boundary", 32'(c), 32'd0);
        wr(B + 32'h18, 32'd1, 3'b010);
        wr(B + 32'h00, 32'd3, 3'b010);
        wr(B + 32'h14, 32'd3, 3'b010);
        address = B + 32'h2C;
        @(negedge clk);
        prev = int'(read_data_clocked);
        chk("fade_start", 32'(prev), 32'd0);
        last_t = 0;
        nchg = 0;
        for (int t = 0; t < 3000 && nchg < 3; t++) begin
            @(negedge clk);
            v = read_data_clocked;
            if (v != 32'(prev)) begin
                chk("fade_step", v, 32'(prev + 1));
                if (nchg > 0) chk("fade_gap", 32'(t - last_t), 32'd512);
                last_t = t;
                prev = int'(v);
                nchg++;
            end
        end
        chk("fade_steps", 32'(nchg), 32'd3);
        repeat (1100) @(negedge clk);
        chk("fade_hold", read_data_clocked, 32'd3);
        wr(B + 32'h0E, 32'hAB, 3'b010);
        rd(B + 32'h0C, 32'd64);
        wr(B + 32'h20, 32'h55, 3'b010);
        rd(B + 32'h20, 32'd0);
        wr(32'h0000_0018, 32'h7, 3'b010);
        wr(B + 32'h18, 32'h9, 3'b011);
        rd(B + 32'h18, 32'd1);
        rd(B + 32'h1C, 32'd0);
        rd(32'h0000_0004, 32'd0);
        wait_red_rise();
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_outputs", {28'd0, red, green, blue, led}, 32'd0);
        chk("async_rst_rdata", read_data_clocked, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(B + 32'h00, 32'd0);
        rd(B + 32'h04, 32'd46);
        rd(B + 32'h0C, 32'd0);
        rd(B + 32'h18, 32'd0);
        rd(B + 32'h2C, 32'd0);
        cnt(1, 300, c);
        chk("post_rst_red", 32'(c), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mmio_pwm.md
MMIO_PWM -- requirements
Module: mmio_pwm

Interface
REQ-001 Parameter BASE_ADDR, default 32'hFFFF_FF00: base of the 256-byte peripheral window; address[31:8] must equal BASE_ADDR[31:8] to select the block.
REQ-002 Parameter PRESCALE_RST, default 16'd46: PRESCALE reset value; with a 12 MHz clk this gives about 1 kHz PWM.
REQ-003 clk  input  1: single clock; all state on its rising edge.
REQ-004 reset_n  input  1: asynchronous, active-low reset.
REQ-005 write_mem  input  1: store strobe from the core, valid for one cycle.
REQ-006 funct3  input  3: store width; accepted values 3'b000 (SB), 3'b001 (SH), 3'b010 (SW).
REQ-007 address  input  32: shared read/write byte address.
REQ-008 write_data  input  32: store data.
REQ-009 read_data_clocked  output  32: registered read-back of the register at `address`.
REQ-010 red, green, blue, led  output  1 each: active-high PWM outputs (the board top inverts them).

Function
REQ-011 Register map (word offsets):
- 0x00 CTRL[1:0]: bit0 EN, bit1 FADE
- 0x04 PRESCALE[15:0]
- 0x08 TGT_LED[7:0]
- 0x0C TGT_R[7:0]
- 0x10 TGT_G[7:0]
- 0x14 TGT_B[7:0]
- 0x18 FADE_RATE[7:0]
- 0x20..0x2C CUR_LED/R/G/B[7:0], read-only
REQ-012 A write is accepted only when all of the following hold: write_mem=1, window hit, address[1:0]=0, accepted funct3, writable offset. The register then takes write_data low bits and the update is visible the next cycle.
REQ-013 Writes that fail REQ-012 (unmapped, misaligned, read-only, or other funct3) are ignored with no side effect.
REQ-014 read_data_clocked updates every cycle with the addressed register, zero-extended. Latency is 1 cycle; unmapped or out-of-window addresses return 0.
REQ-015 Prescaler: pre_cnt counts 0..PRESCALE. A tick fires on the cycle pre_cnt==PRESCALE, and pre_cnt returns to 0 on that cycle. PRESCALE=0 gives a tick every cycle.
REQ-016 A write to PRESCALE clears pre_cnt to 0 in the same update.
REQ-017 pwm_cnt is 8 bits and increments on each tick, wrapping 255 to 0. A period boundary is the tick on which pwm_cnt wraps.
REQ-018 Each channel holds three values: target (TGT), current (CUR) and active duty (ACT). ACT loads from CUR only at a period boundary, so outputs never glitch mid-period.
REQ-019 Channel output = EN && (pwm_cnt < ACT); this comparison is registered, so the output lags pwm_cnt by 1 cycle. Duty 0 keeps the output low; duty 255 keeps it high for 255 of 256 counts.
REQ-020 FSM states:
- DISABLED (EN=0): counters held at 0, outputs 0.
- RUN (EN=1, FADE=0): CUR copies TGT every cycle.
- FADE (EN=1, FADE=1): CUR moves toward TGT in steps.
REQ-021 FSM transitions are evaluated from CTRL each cycle. Entering DISABLED clears pre_cnt, pwm_cnt and fade_cnt; ACT keeps its value.
REQ-022 In FADE, fade_cnt counts period boundaries 0..FADE_RATE. On the boundary where fade_cnt==FADE_RATE, each CUR moves ±1 toward its TGT (no change if equal) and fade_cnt returns to 0.
REQ-023 ACT loads the pre-step CUR on that same boundary; the step is seen in the next period.
REQ-024 A TGT write in the same cycle as a fade step: the step uses the old TGT, and the new TGT is stored.
REQ-025 CUR saturates at 0 and 255 and never wraps.

Reset
REQ-026 While reset_n=0, asynchronously:
- CTRL=0, PRESCALE=PRESCALE_RST, all TGT/CUR/ACT=0, FADE_RATE=0
- pre_cnt, pwm_cnt, fade_cnt = 0; FSM = DISABLED
- read_data_clocked=0; red/green/blue/led=0
REQ-027 Reset asserted mid-period or mid-fade aborts immediately. No state survives; operation resumes only after software reprograms the block.

Structure
REQ-028 Shared package mmio_pkg holds: the register offset localparams, the pwm_state_t enum (DISABLED, RUN, FADE), and the default BASE_ADDR.
REQ-029 Sub-module pwm_channel holds one channel's TGT/CUR/ACT, fade step and compare; mmio_pwm instantiates it four times.
REQ-030 mmio_pwm owns decode, read mux, prescaler, pwm_cnt, fade_cnt and the FSM.

Verification
REQ-031 Reset, then read 0x04 -> read_data_clocked=46 one cycle later; all outputs 0.
REQ-032 Program PRESCALE=0, TGT_R=64, CTRL=1 -> red high for exactly 64 of every 256 cycles, starting after the first period boundary.
REQ-033 Program TGT_G=0, then 255 -> green is constantly low, then high 255/256 of each period; a TGT change mid-period changes nothing until the boundary.
REQ-034 Program FADE_RATE=1, CTRL=3, TGT_B=3 from CUR=0 -> CUR_B reads 1, 2, 3 at every 2nd boundary, then holds.
REQ-035 SW to 0x0E (misaligned), write to 0x20 (read-only), and write outside the window -> no register changes; unmapped read returns 0.
REQ-036 Pulse reset_n low mid-fade with CTRL=3 -> outputs drop to 0 asynchronously; all registers read reset values afterwards.
